// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue.
package if_pkg;

   localparam int              XLEN      = 32;
   localparam logic [XLEN-1:0] BOOT_ADDR = 32'h0000_1000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RESP
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO of {addr, data} fetch entries. The head is read
// straight from the storage registers, so outputs carry no combinational
// path from push/pop. Flush resets pointers and count but leaves storage.
module if_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_ni,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   // Pointer, count and storage update; flush overrides any same-cycle push/pop.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   assign head = mem[rptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: accepts one fetch address at a time, issues a
// single outstanding word request to the icache and queues the returned
// {address, instruction} pairs for decode. A flush empties the queue and
// marks any in-flight request so that its response is discarded.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            fetch_valid_i,
   input  logic [XLEN-1:0] fetch_addr_i,
   output logic            fetch_ready_o,
   output logic            icache_req_o,
   output logic [XLEN-1:0] icache_addr_o,
   input  logic            icache_gnt_i,
   input  logic            icache_rvalid_i,
   input  logic [XLEN-1:0] icache_rdata_i,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_addr_o,
   output logic [XLEN-1:0] instr_data_o,
   input  logic            instr_ready_i
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic            kill_q, kill_d;
   logic [XLEN-1:0] req_addr_q;
   logic [CW-1:0]   count;
   fetch_entry_t    head;
   fetch_entry_t    wdata;
   logic            accept;
   logic            push;
   logic            pop;

   // Only accept when idle and a slot is guaranteed for the response.
   assign fetch_ready_o = (state_q == IDLE) && (count < CW'(DEPTH)) && !flush_i;
   assign accept        = fetch_valid_i && fetch_ready_o;

   assign icache_req_o  = (state_q == WAIT_GNT);
   assign icache_addr_o = {req_addr_q[XLEN-1:2], 2'b00};

   // A killed or same-cycle-flushed response never reaches the queue.
   assign push  = (state_q == WAIT_RESP) && icache_rvalid_i && !kill_q && !flush_i;
   assign wdata = '{addr: req_addr_q, data: icache_rdata_i};

   assign instr_valid_o = (count != '0) && !flush_i;
   assign pop           = instr_valid_o && instr_ready_i;
   assign instr_addr_o  = head.addr;
   assign instr_data_o  = head.data;

   if_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_ni(rst_ni),
      .flush (flush_i),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .head  (head),
      .count (count)
   );

   // State, kill flag and captured request address.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         kill_q     <= 1'b0;
         req_addr_q <= '0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
         if (accept) req_addr_q <= fetch_addr_i;
      end
   end

   // Next-state and kill logic; the response clears kill, a flush mid-request sets it.
   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = WAIT_GNT;
         end
         WAIT_GNT: begin
            if (icache_gnt_i) state_d = WAIT_RESP;
            if (flush_i)      kill_d  = 1'b1;
         end
         WAIT_RESP: begin
            if (icache_rvalid_i) begin
               state_d = IDLE;
               kill_d  = 1'b0;
            end else if (flush_i) begin
               kill_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a cache model answers requests with
// data = aligned_addr - 0xFED, stimulus pushes expected entries, and a
// monitor compares every popped entry against the queue.
module tb_if_fetch_queue;
   import if_pkg::*;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        fetch_valid_i;
   logic [31:0] fetch_addr_i;
   logic        fetch_ready_o;
   logic        icache_req_o;
   logic [31:0] icache_addr_o;
   logic        icache_gnt_i;
   logic        icache_rvalid_i;
   logic [31:0] icache_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_addr_o;
   logic [31:0] instr_data_o;
   logic        instr_ready_i;

   int total  = 0;
   int passed = 0;

   fetch_entry_t exp_q[$];

   // cache model knobs and state
   int          gnt_delay = 0;
   int          rsp_delay = 1;
   int          gnt_cnt   = 0;
   int          rsp_cnt   = 0;
   bit          pending   = 0;
   logic [31:0] pend_addr = '0;

   if_fetch_queue #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .fetch_valid_i  (fetch_valid_i),
      .fetch_addr_i   (fetch_addr_i),
      .fetch_ready_o  (fetch_ready_o),
      .icache_req_o   (icache_req_o),
      .icache_addr_o  (icache_addr_o),
      .icache_gnt_i   (icache_gnt_i),
      .icache_rvalid_i(icache_rvalid_i),
      .icache_rdata_i (icache_rdata_i),
      .instr_valid_o  (instr_valid_o),
      .instr_addr_o   (instr_addr_o),
      .instr_data_o   (instr_data_o),
      .instr_ready_i  (instr_ready_i)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endfunction

   // Cache model: drives gnt/rvalid 1 time unit after each rising edge.
   initial begin
      icache_gnt_i    = 1'b0;
      icache_rvalid_i = 1'b0;
      icache_rdata_i  = '0;
      forever begin
         @(posedge clk); #1;
         icache_gnt_i    = 1'b0;
         icache_rvalid_i = 1'b0;
         if (!rst_ni) begin
            pending = 0;
            gnt_cnt = 0;
         end else begin
            if (pending) begin
               rsp_cnt--;
               if (rsp_cnt == 0) begin
                  icache_rvalid_i = 1'b1;
                  icache_rdata_i  = pend_addr - 32'h0000_0FED;
                  pending         = 0;
               end
            end
            if (icache_req_o && !pending) begin
               if (gnt_cnt >= gnt_delay) begin
                  icache_gnt_i = 1'b1;
                  pending      = 1;
                  pend_addr    = icache_addr_o;
                  rsp_cnt      = rsp_delay;
                  gnt_cnt      = 0;
               end else begin
                  gnt_cnt++;
               end
            end
         end
      end
   end

   // Monitor: compare every popped head against the scoreboard.
   always @(negedge clk) begin
      if (rst_ni && instr_valid_o && instr_ready_i) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL pop_unexpected: got addr 0x%08h data 0x%08h, expected no entry",
                     instr_addr_o, instr_data_o);
         end else begin
            fetch_entry_t e;
            e = exp_q.pop_front();
            chk("pop_addr", instr_addr_o, e.addr);
            chk("pop_data", instr_data_o, e.data);
         end
      end
   end

   // Offer one address, wait (bounded) for acceptance, record the expected entry.
   // Returns 2 time units after the accepting edge.
   task automatic fetch(input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      fetch_valid_i = 1'b1;
      fetch_addr_i  = a;
      @(negedge clk);
      while (!fetch_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!fetch_ready_o) begin
         total++;
         $display("FAIL accept_timeout: addr 0x%08h never accepted, expected acceptance", a);
         fetch_valid_i = 1'b0;
      end else begin
         @(posedge clk);
         exp_q.push_back('{addr: a, data: d});
         #2;
         fetch_valid_i = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      bit seen;
      rst_ni        = 1'b0;
      flush_i       = 1'b0;
      fetch_valid_i = 1'b0;
      fetch_addr_i  = '0;
      instr_ready_i = 1'b0;

      // reset values before any clock edge
      #3;
      chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
      chk("rst_icache_req",  32'(icache_req_o),  32'd0);
      chk("rst_icache_addr", icache_addr_o,      32'h0);
      chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_instr_addr",  instr_addr_o,       32'h0);
      chk("rst_instr_data",  instr_data_o,       32'h0);
      repeat (2) @(posedge clk);
      #2 rst_ni = 1'b1;
      @(posedge clk); #2;

      // 1: boot address, immediate grant, rvalid next cycle
      fetch(BOOT_ADDR, 32'h0000_0013);
      @(negedge clk);
      chk("t1_req",          32'(icache_req_o),  32'd1);
      chk("t1_icache_addr",  icache_addr_o,      32'h0000_1000);
      @(posedge clk); @(negedge clk);
      chk("t2_instr_valid",  32'(instr_valid_o), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("t3_instr_valid",  32'(instr_valid_o), 32'd1);
      chk("t3_instr_addr",   instr_addr_o,       32'h0000_1000);
      chk("t3_instr_data",   instr_data_o,       32'h0000_0013);
      chk("t3_fetch_ready",  32'(fetch_ready_o), 32'd1);
      @(posedge clk); #2 instr_ready_i = 1'b1;
      repeat (2) @(posedge clk); #2;

      // 2: unaligned address
      fetch(32'h0000_1006, 32'h0000_0017);
      @(negedge clk);
      chk("unal_icache_addr", icache_addr_o, 32'h0000_1004);
      repeat (5) @(posedge clk); #2;

      // 3: fill the queue with decode stalled
      instr_ready_i = 1'b0;
      fetch(32'h0000_1000, 32'h0000_0013);
      fetch(32'h0000_1004, 32'h0000_0017);
      fetch(32'h0000_1008, 32'h0000_001B);
      fetch(32'h0000_100C, 32'h0000_001F);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("full_ready_low",  32'(fetch_ready_o), 32'd0);
      chk("full_valid",      32'(instr_valid_o), 32'd1);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (fetch_ready_o) bad = 1;
      end
      chk("full_ready_held", 32'(bad), 32'd0);
      @(posedge clk); #2 instr_ready_i = 1'b1;
      @(posedge clk); #2 instr_ready_i = 1'b0;
      @(negedge clk);
      chk("pop_reenables",   32'(fetch_ready_o), 32'd1);
      @(posedge clk); #2 instr_ready_i = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("drain_empty",     32'(exp_q.size()),  32'd0);
      chk("drain_valid",     32'(instr_valid_o), 32'd0);
      @(posedge clk); #2;

      // 4: flush in WAIT_GNT with a 3-cycle grant delay
      gnt_delay = 3;
      fetch(32'h0000_1010, 32'h0000_0023);
      flush_i = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("kill_flush_valid", 32'(instr_valid_o), 32'd0);
      chk("kill_flush_ready", 32'(fetch_ready_o), 32'd0);
      @(posedge clk); #2 flush_i = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (instr_valid_o) bad = 1;
      end
      chk("kill_dropped",     32'(bad),           32'd0);
      chk("kill_back_idle",   32'(fetch_ready_o), 32'd1);
      @(posedge clk); #2;
      gnt_delay = 0;
      fetch(32'h0000_1014, 32'h0000_0027);
      repeat (5) @(posedge clk); #2;
      chk("kill_next_ok",     32'(exp_q.size()),  32'd0);

      // 5: flush with 2 queued entries, same cycle as pop and rvalid
      instr_ready_i = 1'b0;
      fetch(32'h0000_1020, 32'h0000_0033);
      fetch(32'h0000_1024, 32'h0000_0037);
      rsp_delay = 3;
      fetch(32'h0000_1028, 32'h0000_003B);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #2;
         if (icache_rvalid_i) seen = 1;
      end
      chk("flush_rvalid_seen", 32'(seen), 32'd1);
      flush_i       = 1'b1;
      instr_ready_i = 1'b1;
      @(negedge clk);
      chk("flush_valid_low",   32'(instr_valid_o), 32'd0);
      @(posedge clk); #2;
      flush_i       = 1'b0;
      instr_ready_i = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("flush_count_zero",  32'(instr_valid_o), 32'd0);
      chk("flush_ready",       32'(fetch_ready_o), 32'd1);
      @(posedge clk); #2;
      rsp_delay     = 1;
      instr_ready_i = 1'b1;
      fetch(32'h0000_1030, 32'h0000_0043);
      repeat (5) @(posedge clk); #2;
      chk("flush_next_ok",     32'(exp_q.size()),  32'd0);

      // 6: asynchronous reset while in WAIT_RESP
      instr_ready_i = 1'b0;
      fetch(32'h0000_1044, 32'h0000_0057);
      repeat (3) @(posedge clk); #2;
      rsp_delay = 5;
      fetch(32'h0000_1048, 32'h0000_005B);
      @(posedge clk); #2;
      @(negedge clk);
      chk("pre_rst_valid",  32'(instr_valid_o), 32'd1);
      chk("pre_rst_addr",   instr_addr_o,       32'h0000_1044);
      exp_q.delete();
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_fetch_ready", 32'(fetch_ready_o), 32'd1);
      chk("arst_icache_req",  32'(icache_req_o),  32'd0);
      chk("arst_icache_addr", icache_addr_o,      32'h0);
      chk("arst_instr_valid", 32'(instr_valid_o), 32'd0);
      chk("arst_instr_addr",  instr_addr_o,       32'h0);
      chk("arst_instr_data",  instr_data_o,       32'h0);
      repeat (2) @(posedge clk);
      #2 rst_ni = 1'b1;
      @(negedge clk);
      chk("post_rst_valid",   32'(instr_valid_o), 32'd0);
      chk("post_rst_ready",   32'(fetch_ready_o), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch queue sitting directly downstream of the next-PC stage. Accepts one fetch address per handshake, issues a single-outstanding word request to the instruction cache, and buffers returned {address, instruction} pairs in a small FIFO for decode. Provides flush support: it discards queued entries and drops any in-flight cache response.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard queue contents and any in-flight response.
- fetch_valid_i  in  1  fetch address offered by the next-PC stage.
- fetch_addr_i  in  32  fetch address; byte address.
- fetch_ready_o  out  1  address accepted when high together with fetch_valid_i.
- icache_req_o  out  1  cache request.
- icache_addr_o  out  32  word-aligned request address.
- icache_gnt_i  in  1  request granted this cycle.
- icache_rvalid_i  in  1  response data valid; exactly one per grant, in order, no earlier than the cycle after the grant.
- icache_rdata_i  in  32  instruction word.
- instr_valid_o  out  1  FIFO head valid.
- instr_addr_o  out  32  head address, as accepted.
- instr_data_o  out  32  head instruction.
- instr_ready_i  in  1  decode pops the head.

## Operation
- FSM states are IDLE, WAIT_GNT and WAIT_RESP. There is also a kill_q bit.
- fetch_ready_o = (state==IDLE) && (count<DEPTH) && !flush_i.
- IDLE: on accept, latch the address into req_addr_q and go to WAIT_GNT.
- WAIT_GNT: icache_req_o=1. icache_addr_o={req_addr_q[31:2],2'b00}. The request is held until icache_gnt_i, then the FSM moves to WAIT_RESP.
- WAIT_RESP: on icache_rvalid_i, push {req_addr_q, icache_rdata_i} unless kill_q or flush_i is set. Then clear kill_q and go to IDLE.
- At most one request is outstanding. Because acceptance requires count<DEPTH, a push can never find the FIFO full.
- Pop: when instr_valid_o && instr_ready_i, the head advances.
- A push and a pop in the same cycle leave count unchanged.
- instr_valid_o = (count!=0) && !flush_i.
- Flush:
  - The FIFO is cleared the same cycle; pointers and count go to 0, and any same-cycle push or pop is ignored.
  - In WAIT_GNT or WAIT_RESP, kill_q is set. The request still completes and its response is dropped.
  - A flush in the same cycle as rvalid simply drops that response; kill_q stays clear.
- Reset values: state IDLE, kill_q 0, count 0, pointers 0, storage 0.
  - icache_req_o 0, icache_addr_o 0, instr_valid_o 0, instr_addr_o 0, instr_data_o 0.
  - fetch_ready_o 1 (upstream does not offer during reset).
- Reset mid-request abandons the request. The cache is reset by the same rst_ni.

## Timing
- Accept at cycle t gives icache_req_o at t+1.
- With a same-cycle grant at t+1 and rvalid at t+2, the entry is visible on instr_* at t+3, and the next accept is possible at t+3.
- The minimum issue interval is therefore 3 cycles.
- instr_* are registered FIFO outputs. instr_valid_o depends combinationally only on flush_i.
- Stalls:
  - A grant stall holds req and addr stable.
  - A response stall holds WAIT_RESP indefinitely.
  - A full FIFO holds fetch_ready_o low until a pop.
- count is log2(DEPTH)+1 bits wide. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.

## Structure
- Shared package if_pkg holds:
  - XLEN=32 and BOOT_ADDR=32'h0000_1000.
  - fetch_state_e, with values IDLE, WAIT_GNT and WAIT_RESP.
  - fetch_entry_t, a packed struct {addr, data}.
- Sub-module if_fifo: a synchronous FIFO of fetch_entry_t with parameter DEPTH, push/pop/flush inputs, head/count outputs, and an asynchronous active-low reset.
- The FSM and kill logic live in if_fetch_queue.

## Test plan
- After reset, offer 0x0000_1000 with grant immediate and rvalid next cycle, data 0x0000_0013.
  - Required: icache_addr_o=0x0000_1000 at t+1.
  - Required: instr_addr_o=0x0000_1000 and instr_data_o=0x0000_0013 valid at t+3.
- Offer the unaligned address 0x0000_1006.
  - Required: icache_addr_o=0x0000_1004 and instr_addr_o=0x0000_1006.
- Hold instr_ready_i=0 and fetch 4 sequential addresses from 0x1000.
  - Required: fetch_ready_o drops after the 4th push.
  - Required: one pop re-enables acceptance; entries pop in order 0x1000, 0x1004, 0x1008, 0x100C.
- Flush while in WAIT_GNT with grant delayed 3 cycles, then rvalid.
  - Required: the response is dropped, instr_valid_o stays 0 and the FSM returns to IDLE.
  - Required: the next fetch proceeds normally.
- Flush with 2 queued entries in the same cycle as a pop and an rvalid.
  - Required: count=0 next cycle and instr_valid_o=0 during the flush.
- Assert rst_ni low while in WAIT_RESP.
  - Required: all outputs return to their reset values immediately, without a clock edge.
